pmod_als_spi_receiver: RTL and testbench
========================================

Name: pmod_als_spi_receiver

Overview:
- SPI initiator that reads the PMOD ALS light sensor: drives cs/sck, shifts in sdo and returns the 8-bit light value.
- Sits inside mfp_system next to the AHB-Lite GPIO/peripheral slave, which issues start and reads value/valid.
- Peer of the ALS sensor and its testbench stub: the sensor shifts a 16-bit packet {4'b0, value[7:0], 4'b0} MSB-first on sck falling edges while cs is low, and reloads it on sck falling edges while cs is high.

Parameters:
- SCK_HALF, 8: clk cycles per sck half-period; legal range ≥2. sck period = 2*SCK_HALF clk.
- CS_GAP, 2: minimum full sck periods cs stays high between transactions. Legal range ≥1; the sensor needs at least one sck falling edge with cs high to reload.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  one-cycle request for a conversion; honoured only when busy=0
- busy  output  1  transaction (or post-transaction gap) in progress
- cs  output  1  sensor chip select, active-low
- sck  output  1  serial clock, free-running
- sdo  input  1  serial data from sensor
- value  output  8  last captured light value (packet[11:4])
- packet  output  16  last raw captured packet
- frame_err  output  1  last packet had nonzero packet[15:12] or packet[3:0]
- valid  output  1  one-cycle pulse when value/packet/frame_err update

Behaviour:
- Reset (rst_n=0 sampled at posedge clk): cs=1, sck=1, busy=0, valid=0, value=0, packet=0, frame_err=0; half-period counter=0; state=IDLE.
- A mid-transfer reset discards partial data, raises cs on the next clk edge, and never pulses valid.
- sck generator:
  - Counter runs 0..SCK_HALF-1; sck toggles when it reaches SCK_HALF-1.
  - sck runs in every state, including IDLE.
  - rise strobe = cycle in which sck goes 0→1; fall strobe = 1→0.
  - sdo is sampled on the clk edge that produces a rise strobe; the sensor changed it on the preceding fall, so it is stable.
- State machine:
  - IDLE: cs=1, busy=0. start=1 → ARM, busy=1 next cycle.
  - ARM: cs=1. Wait for a rise strobe, then enter SHIFT; cs=0 from the same edge. cs therefore always falls while sck is high, and the sensor first drives bit15 on the next fall.
  - SHIFT: cs=0, bit counter 0..15.
    - Each rise strobe: shreg <= {shreg[14:0], sdo}; counter increments.
    - On the 16th rise: cs=1 on that same edge; packet <= captured 16 bits.
    - value <= captured[11:4]; frame_err <= |captured[15:12] or |captured[3:0].
    - valid=1 for exactly that one cycle; go to GAP.
  - GAP: cs=1, busy=1. Count CS_GAP rise strobes, then return to IDLE (busy=0 the following cycle).
- start while busy=1 is ignored: not queued, no error.
- A start in the same cycle busy falls is ignored; start in the first cycle of IDLE is accepted.
- Latency from accepted start to valid: at most 2*SCK_HALF + 16*2*SCK_HALF + 1 clk cycles. Minimum is 16*2*SCK_HALF + 1 when ARM sees a rise immediately.
- value/packet/frame_err hold their values until the next valid; they never change outside a valid cycle.
- Bit order: MSB first. First sampled bit is packet[15].

Decomposition:
- Package pmod_als_pkg:
  - ALS_PACKET_W=16, ALS_DATA_W=8, ALS_DATA_LSB=4, ALS_PAD_W=4.
  - State encoding: IDLE, ARM, SHIFT, GAP as 2-bit localparams.
  - Bit-counter width of 4.
- Sub-module pmod_als_spi_sck_gen:
  - Parameter SCK_HALF; ports clk, rst_n, sck, sck_rise, sck_fall.
  - Free-running divider; sck resets high with counter 0.

Test Plan:
- Sensor stub value=8'hAB, SCK_HALF=8, single start → cs low for exactly 16 sck periods; valid pulses once; packet=16'h0AB0, value=8'hAB, frame_err=0; cs high within 1 clk of the 16th sck rise.
- Stub values 8'h00 then 8'hFF, back-to-back starts each issued in the first IDLE cycle → value 00 then FF. cs high for ≥CS_GAP sck periods between frames; a start pulse during GAP is ignored (exactly two valids).
- sdo tied to 1 → packet=16'hFFFF, value=8'hFF, frame_err=1; sdo tied to 0 → packet=0, value=0, frame_err=0.
- rst_n=0 for 1 clk after the 7th sck rise of a frame (prior value=8'hAB) → next cycle cs=1, busy=0, value=0, no valid. A new start then returns 8'hAB correctly.
- start asserted on every clk for 40 sck periods → valid pulses occur only once per full ARM+SHIFT+GAP sequence. A checker confirms cs never falls while sck=0 and sdo is only sampled on rise strobes.
- SCK_HALF=2 corner: stub 8'h5A → value=8'h5A. Accepted-start-to-valid latency is within [65, 69] clk cycles.

Source files
------------

// File: rtl/pmod_als_pkg.sv
// Shared constants, state encoding and packet layout for the PMOD ALS SPI reader.
package pmod_als_pkg;

    localparam int unsigned ALS_PACKET_W  = 16;
    localparam int unsigned ALS_DATA_W    = 8;
    localparam int unsigned ALS_DATA_LSB  = 4;
    localparam int unsigned ALS_PAD_W     = 4;
    localparam int unsigned ALS_BIT_CNT_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARM   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    // Sensor frame: four leading zeros, light value, four trailing zeros.
    typedef struct packed {
        logic [ALS_PAD_W-1:0]  pad_hi;
        logic [ALS_DATA_W-1:0] data;
        logic [ALS_PAD_W-1:0]  pad_lo;
    } als_packet_t;

    // A frame is malformed when either padding nibble is not all zeros.
    function automatic logic als_frame_err(input als_packet_t p);
        return (|p.pad_hi) | (|p.pad_lo);
    endfunction

endpackage

// File: rtl/pmod_als_spi_sck_gen.sv
// Free-running SPI clock divider with single-cycle rise/fall strobes.
module pmod_als_spi_sck_gen #(
    parameter int unsigned SCK_HALF = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic sck,
    output logic sck_rise,
    output logic sck_fall
);

    localparam int unsigned CNT_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCK_HALF - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_LAST);

    // Strobes flag the clk edge on which sck is about to toggle.
    assign sck_rise = wrap & ~sck;
    assign sck_fall = wrap & sck;

    // Half-period counter; sck toggles each time the counter wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b1;
        end else if (wrap) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pmod_als_spi_receiver.sv
// SPI initiator that reads one 16-bit frame from the PMOD ALS light sensor per start.
module pmod_als_spi_receiver
    import pmod_als_pkg::*;
#(
    parameter int unsigned SCK_HALF = 8,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    cs,
    output logic                    sck,
    input  logic                    sdo,
    output logic [ALS_DATA_W-1:0]   value,
    output logic [ALS_PACKET_W-1:0] packet,
    output logic                    frame_err,
    output logic                    valid
);

    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [ALS_BIT_CNT_W-1:0] BIT_LAST = ALS_BIT_CNT_W'(ALS_PACKET_W - 1);

    logic                     sck_rise;
    logic                     sck_fall;
    logic                     unused_sck_fall;

    logic [1:0]               state;
    logic [1:0]               state_d;
    logic [ALS_PACKET_W-2:0]  shreg;
    logic [ALS_PACKET_W-2:0]  shreg_d;
    logic [ALS_BIT_CNT_W-1:0] bit_cnt;
    logic [ALS_BIT_CNT_W-1:0] bit_cnt_d;
    logic [GAP_W-1:0]         gap_cnt;
    logic [GAP_W-1:0]         gap_cnt_d;
    logic                     cs_d;
    logic                     busy_d;
    logic                     valid_d;
    logic [ALS_DATA_W-1:0]    value_d;
    logic [ALS_PACKET_W-1:0]  packet_d;
    logic                     frame_err_d;
    logic [ALS_PACKET_W-1:0]  shift_in;
    als_packet_t              cap;

    pmod_als_spi_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck      (sck),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    // Sampling happens only on rises; the fall strobe is not needed here.
    assign unused_sck_fall = sck_fall;

    // Word as it stands once the current sdo bit is shifted in.
    assign shift_in = {shreg, sdo};
    assign cap      = als_packet_t'(shift_in);

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state;
        cs_d        = cs;
        busy_d      = busy;
        valid_d     = 1'b0;
        shreg_d     = shreg;
        bit_cnt_d   = bit_cnt;
        gap_cnt_d   = gap_cnt;
        value_d     = value;
        packet_d    = packet;
        frame_err_d = frame_err;

        case (state)
            IDLE: begin
                cs_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d = ARM;
                    busy_d  = 1'b1;
                end
            end

            // Select the sensor on a rise so cs always falls while sck is high.
            ARM: begin
                cs_d   = 1'b1;
                busy_d = 1'b1;
                if (sck_rise) begin
                    state_d   = SHIFT;
                    cs_d      = 1'b0;
                    bit_cnt_d = '0;
                end
            end

            SHIFT: begin
                if (sck_rise) begin
                    shreg_d = shift_in[ALS_PACKET_W-2:0];
                    if (bit_cnt == BIT_LAST) begin
                        cs_d        = 1'b1;
                        packet_d    = shift_in;
                        value_d     = cap.data;
                        frame_err_d = als_frame_err(cap);
                        valid_d     = 1'b1;
                        gap_cnt_d   = '0;
                        state_d     = GAP;
                    end else begin
                        bit_cnt_d = bit_cnt + ALS_BIT_CNT_W'(1);
                    end
                end
            end

            // Hold cs high long enough for the sensor to reload its frame.
            GAP: begin
                cs_d   = 1'b1;
                busy_d = 1'b1;
                if (sck_rise) begin
                    if (gap_cnt == GAP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        gap_cnt_d = gap_cnt + GAP_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cs        <= 1'b1;
            busy      <= 1'b0;
            valid     <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            value     <= '0;
            packet    <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cs        <= cs_d;
            busy      <= busy_d;
            valid     <= valid_d;
            shreg     <= shreg_d;
            bit_cnt   <= bit_cnt_d;
            gap_cnt   <= gap_cnt_d;
            value     <= value_d;
            packet    <= packet_d;
            frame_err <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_pmod_als_spi_receiver.sv
// Scoreboard bench for the PMOD ALS SPI reader with a behavioural sensor stub.
module tb_pmod_als_spi_receiver;

    localparam int unsigned H  = 8;
    localparam int unsigned G  = 2;
    localparam int unsigned H2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Main DUT (SCK_HALF=8)
    logic        rst_n, start, busy, cs, sck, sdo, frame_err, valid;
    logic [7:0]  value;
    logic [15:0] packet;

    // Corner DUT (SCK_HALF=2)
    logic        rst2_n, start2, busy2, cs2, sck2, sdo2, frame_err2, valid2;
    logic [7:0]  value2;
    logic [15:0] packet2;

    pmod_als_spi_receiver #(.SCK_HALF(H), .CS_GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .cs(cs), .sck(sck),
        .sdo(sdo), .value(value), .packet(packet), .frame_err(frame_err), .valid(valid)
    );

    pmod_als_spi_receiver #(.SCK_HALF(H2), .CS_GAP(G)) dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start2), .busy(busy2), .cs(cs2), .sck(sck2),
        .sdo(sdo2), .value(value2), .packet(packet2), .frame_err(frame_err2), .valid(valid2)
    );

    // Sensor stubs: reload while deselected, shift MSB-first on sck falls while selected.
    logic [15:0] stub_raw = 16'h0;
    logic [15:0] stub_sh  = 16'h0;
    logic        stub_sdo = 1'b0;
    logic        tie_en   = 1'b0;
    logic        tie_val  = 1'b0;
    always @(negedge sck) begin
        if (cs) stub_sh <= stub_raw;
        else begin
            stub_sdo <= stub_sh[15];
            stub_sh  <= {stub_sh[14:0], 1'b0};
        end
    end
    assign sdo = tie_en ? tie_val : stub_sdo;

    logic [15:0] stub2_raw = 16'h0;
    logic [15:0] stub2_sh  = 16'h0;
    logic        stub2_sdo = 1'b0;
    always @(negedge sck2) begin
        if (cs2) stub2_sh <= stub2_raw;
        else begin
            stub2_sdo <= stub2_sh[15];
            stub2_sh  <= {stub2_sh[14:0], 1'b0};
        end
    end
    assign sdo2 = stub2_sdo;

    // Reference model: light value is bits 11..4, any nonzero pad nibble is an error.
    function automatic logic [7:0] model_value(input logic [15:0] raw);
        return 8'((raw >> 4) & 16'h00FF);
    endfunction
    function automatic logic model_err(input logic [15:0] raw);
        return (raw & 16'hF00F) != 16'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: actual=%0d required=[%0d,%0d] at %0t", nm, act, lo, hi, $time);
        end
    endtask

    // Scoreboard monitor: every valid pops one expected frame; outputs must hold otherwise.
    logic [15:0] exp_q[$];
    logic [15:0] held = 16'h0;
    logic [15:0] mon_e;
    logic        spam_mode = 1'b0;
    int unsigned spam_t[$];
    always @(negedge clk) begin
        if (rst_n === 1'b0) begin
            held = 16'h0;
        end else if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(valid), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("packet", 32'(packet), 32'(mon_e));
                chk("value", 32'(value), 32'(model_value(mon_e)));
                chk("frame_err", 32'(frame_err), 32'(model_err(mon_e)));
                chk("cs_high_at_valid", 32'(cs), 32'(1));
                held = mon_e;
            end
            if (spam_mode) spam_t.push_back(cyc);
        end else begin
            chk("hold_outputs", {7'h0, frame_err, value, packet},
                {7'h0, model_err(held), model_value(held), held});
        end
    end

    // cs framing: falls only with sck high, low for 16 sck periods, gap at least CS_GAP periods.
    int          rst_events = 0;
    int          rst_seen_len = 0;
    int          rst_seen_gap = 0;
    logic        cs_q = 1'b1;
    logic        had_frame = 1'b0;
    int unsigned low_len = 0;
    int unsigned high_len = 0;
    always @(negedge clk) begin
        if (cs_q && !cs) begin
            chk("cs_fall_sck_high", 32'(sck), 32'(1));
            if (had_frame && rst_seen_gap == rst_events)
                chk("cs_gap_long_enough", 32'(high_len >= 2 * H * G), 32'(1));
            rst_seen_gap = rst_events;
            low_len = 0;
        end
        if (!cs_q && cs) begin
            if (rst_seen_len == rst_events) chk("cs_low_len", low_len, 32 * H);
            rst_seen_len = rst_events;
            had_frame = 1'b1;
            high_len = 0;
        end
        if (!cs) low_len++;
        else high_len++;
        cs_q = cs;
    end

    logic cs2_q = 1'b1;
    always @(negedge clk) begin
        if (cs2_q && !cs2) chk("cs2_fall_sck_high", 32'(sck2), 32'(1));
        cs2_q = cs2;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) chk("wait_idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (valid !== 1'b1) chk("valid_timeout", 32'(valid), 32'(1));
    endtask

    // Load the stub, issue one accepted start and check accept-to-valid latency.
    task automatic do_frame(input logic [15:0] raw, input logic [15:0] expect_raw);
        int n;
        stub_raw = raw;
        repeat (4 * H) @(negedge clk);
        wait_idle();
        #1 start = 1'b1;
        exp_q.push_back(expect_raw);
        @(negedge clk);
        #1 start = 1'b0;
        wait_valid(n);
        chk_range("latency", n, 32 * H + 1, 34 * H + 1);
        @(negedge clk);
        wait_idle();
    endtask

    logic done2 = 1'b0;

    // Corner instance: fast sck, tighter latency window.
    initial begin
        int n;
        logic [15:0] raw;
        rst2_n = 1'b0;
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst2_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            raw = (i == 0) ? 16'h05A0 : 16'($urandom);
            stub2_raw = raw;
            repeat (8 * H2) @(negedge clk);
            n = 0;
            while (busy2 !== 1'b0 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            #1 start2 = 1'b1;
            @(negedge clk);
            #1 start2 = 1'b0;
            n = 0;
            while (valid2 !== 1'b1 && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk_range("h2_latency", n, 65, 69);
            chk("h2_packet", 32'(packet2), 32'(raw));
            chk("h2_value", 32'(value2), 32'(model_value(raw)));
            chk("h2_frame_err", 32'(frame_err2), 32'(model_err(raw)));
            @(negedge clk);
            chk("h2_valid_one_cycle", 32'(valid2), 32'(0));
        end
        done2 = 1'b1;
    end

    initial begin
        int n;
        int rises;
        logic prev_s;
        logic [15:0] r;

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {22'h0, cs, sck, busy, valid, frame_err, value[0], packet[3:0]},
            {22'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        chk("rst_value", 32'(value), 32'(0));
        chk("rst_packet", 32'(packet), 32'(0));
        #1 rst_n = 1'b1;

        // Single frame of a well-formed value.
        do_frame(16'h0AB0, 16'h0AB0);

        // Back-to-back frames with a start issued in the first IDLE cycle, plus one ignored during GAP.
        stub_raw = 16'h0000;
        repeat (4 * H) @(negedge clk);
        wait_idle();
        #1 start = 1'b1;
        exp_q.push_back(16'h0000);
        @(negedge clk);
        #1 start = 1'b0;
        wait_valid(n);
        #1 stub_raw = 16'h0FF0;
        repeat (2 * H) @(negedge clk);
        chk("busy_in_gap", 32'(busy), 32'(1));
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        wait_idle();
        #1 start = 1'b1;
        exp_q.push_back(16'h0FF0);
        @(negedge clk);
        #1 start = 1'b0;
        chk("first_idle_start_taken", 32'(busy), 32'(1));
        wait_valid(n);
        @(negedge clk);
        wait_idle();
        repeat (40 * H) @(negedge clk);
        chk("two_valids_only", 32'(exp_q.size()), 32'(0));

        // sdo tied high, then low.
        tie_en  = 1'b1;
        tie_val = 1'b1;
        do_frame(16'h1234, 16'hFFFF);
        tie_val = 1'b0;
        do_frame(16'h1234, 16'h0000);
        tie_en  = 1'b0;

        // Random frames, half of them with valid padding.
        for (int i = 0; i < 6; i++) begin
            r = 16'($urandom);
            if (i % 2 == 0) r = r & 16'h0FF0;
            do_frame(r, r);
        end

        // Reset after the 7th sck rise of a frame.
        do_frame(16'h0AB0, 16'h0AB0);
        stub_raw = 16'h0AB0;
        wait_idle();
        #1 start = 1'b1;
        exp_q.push_back(16'h0AB0);
        @(negedge clk);
        #1 start = 1'b0;
        n = 0;
        while (cs !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        prev_s = sck;
        rises = 0;
        while (rises < 7 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!prev_s && sck) rises++;
            prev_s = sck;
        end
        chk("reset_point_reached", rises, 7);
        #1 rst_n = 1'b0;
        rst_events++;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_cs", 32'(cs), 32'(1));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_value", 32'(value), 32'(0));
        chk("midrst_valid", 32'(valid), 32'(0));
        #1 rst_n = 1'b1;
        repeat (40 * H) @(negedge clk);
        do_frame(16'h0AB0, 16'h0AB0);

        // start held for 40 sck periods: one valid per full ARM+SHIFT+GAP sequence.
        stub_raw = 16'h0C30;
        repeat (4 * H) @(negedge clk);
        wait_idle();
        repeat (3) exp_q.push_back(16'h0C30);
        spam_mode = 1'b1;
        #1 start = 1'b1;
        repeat (80 * H) @(negedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        wait_idle();
        repeat (4 * H) @(negedge clk);
        spam_mode = 1'b0;
        chk("spam_valid_count", 32'(spam_t.size()), 32'(3));
        for (int i = 1; i < spam_t.size(); i++)
            chk("spam_interval", spam_t[i] - spam_t[i-1], 2 * H * (G + 17));

        n = 0;
        while (!done2 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("h2_done", 32'(done2), 32'(1));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
